// File: rtl/queue_dispatcher.sv
// Client queue dispatcher: counts arriving clients, latches teller requests and
// hands out tickets round-robin, at most one dispatch every two cycles.
module queue_dispatcher #(
    parameter int N_TELLERS = 3,
    parameter int DEPTH     = 8,
    parameter int TW        = 8,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int GW       = $clog2(N_TELLERS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 client_in,
    input  logic [N_TELLERS-1:0] teller_req,
    output logic [CW-1:0]        q_count,
    output logic                 q_empty,
    output logic                 q_full,
    output logic                 q_drop,
    output logic [N_TELLERS-1:0] teller_pending,
    output logic                 serve_valid,
    output logic [GW-1:0]        serve_teller,
    output logic [TW-1:0]        serve_ticket
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t               state;
    state_t               next_state;
    logic                 client_prev;
    logic [N_TELLERS-1:0] teller_prev;
    logic                 client_rise;
    logic [N_TELLERS-1:0] teller_rise;
    logic [TW-1:0]        issue_cnt;
    logic [TW-1:0]        serve_cnt;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        grant;
    logic [GW-1:0]        idx;
    logic                 found;
    logic [N_TELLERS-1:0] grant_mask;
    logic                 launch;
    logic                 accept;
    logic                 drop;

    assign client_rise = client_in & ~client_prev;
    assign teller_rise = teller_req & ~teller_prev;
    assign q_empty     = (q_count == '0);
    assign q_full      = (q_count == CW'(DEPTH));
    assign serve_valid = (state == SERVE);
    assign launch      = (state == IDLE) && (|teller_pending) && !q_empty;
    // A dispatch launching on the same edge frees a slot, so a full queue still accepts.
    assign accept      = client_rise && (!q_full || launch);
    assign drop        = client_rise && q_full && !launch;
    assign grant_mask  = {N_TELLERS{launch}} & (N_TELLERS'(1) << grant);

    // Round-robin search beginning just after the last granted teller.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_TELLERS; k++) begin
            idx = GW'((int'(last_grant) + k) % N_TELLERS);
            if (!found && teller_pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (launch) next_state = SERVE;
            SERVE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            client_prev    <= 1'b0;
            teller_prev    <= '0;
            q_count        <= '0;
            q_drop         <= 1'b0;
            teller_pending <= '0;
            issue_cnt      <= '0;
            serve_cnt      <= '0;
            serve_teller   <= '0;
            serve_ticket   <= '0;
            last_grant     <= GW'(N_TELLERS - 1);
        end else begin
            client_prev <= client_in;
            teller_prev <= teller_req;
            q_drop      <= drop;
            if (accept) begin
                issue_cnt <= issue_cnt + TW'(1);
            end
            case ({accept, launch})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
            // A fresh request for the granted teller outranks the clear.
            teller_pending <= (teller_pending & ~grant_mask) | teller_rise;
            if (launch) begin
                serve_teller <= grant;
                serve_ticket <= serve_cnt;
                serve_cnt    <= serve_cnt + TW'(1);
                last_grant   <= grant;
            end
        end
    end

endmodule

// File: tb/tb_queue_dispatcher.sv
// Scoreboard bench for queue_dispatcher: directed scenarios push expected
// dispatches, a negedge monitor pops and compares them.
module tb_queue_dispatcher;

    logic       clk;
    logic       reset_n;
    logic       client_in;
    logic [2:0] teller_req;
    logic [3:0] q_count;
    logic       q_empty;
    logic       q_full;
    logic       q_drop;
    logic [2:0] teller_pending;
    logic       serve_valid;
    logic [1:0] serve_teller;
    logic [7:0] serve_ticket;

    typedef struct packed {
        logic [1:0] teller;
        logic [7:0] ticket;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   drop_count;
    int   drop_at;
    logic drop_seen;

    queue_dispatcher #(.N_TELLERS(3), .DEPTH(8), .TW(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .client_in      (client_in),
        .teller_req     (teller_req),
        .q_count        (q_count),
        .q_empty        (q_empty),
        .q_full         (q_full),
        .q_drop         (q_drop),
        .teller_pending (teller_pending),
        .serve_valid    (serve_valid),
        .serve_teller   (serve_teller),
        .serve_ticket   (serve_ticket)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] actual, logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endfunction

    // Every dispatch pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && serve_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_dispatch", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("serve_teller", 32'(serve_teller), 32'(mon_e.teller));
                check("serve_ticket", 32'(serve_ticket), 32'(mon_e.ticket));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        client_in  = 1'b0;
        teller_req = 3'b000;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic pulse_client(output logic drop_flag);
        client_in = 1'b1;
        tick();
        drop_flag = q_drop;
        client_in = 1'b0;
        tick();
    endtask

    task automatic pulse_teller(input logic [2:0] mask);
        teller_req = mask;
        tick();
        teller_req = 3'b000;
        tick();
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_q_count"}, 32'(q_count), 32'd0);
        check({tag, "_q_empty"}, 32'(q_empty), 32'd1);
        check({tag, "_q_full"}, 32'(q_full), 32'd0);
        check({tag, "_q_drop"}, 32'(q_drop), 32'd0);
        check({tag, "_serve_valid"}, 32'(serve_valid), 32'd0);
        check({tag, "_serve_teller"}, 32'(serve_teller), 32'd0);
        check({tag, "_serve_ticket"}, 32'(serve_ticket), 32'd0);
        check({tag, "_pending"}, 32'(teller_pending), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        client_in  = 1'b0;
        teller_req = 3'b000;
        #3;
        check_reset_state("reset");
        apply_reset();
        check_reset_state("post_reset");

        // Three clients, then teller 1 gets ticket 0.
        repeat (3) pulse_client(drop_seen);
        check("s1_q_count_3", 32'(q_count), 32'd3);
        sb.push_back('{teller: 2'd1, ticket: 8'd0});
        teller_req = 3'b010;
        tick();
        check("s1_pending", 32'(teller_pending), 32'b010);
        teller_req = 3'b000;
        tick();
        check("s1_serve_valid", 32'(serve_valid), 32'd1);
        check("s1_q_count_2", 32'(q_count), 32'd2);
        tick();
        check("s1_serve_one_cycle", 32'(serve_valid), 32'd0);
        check("s1_pending_clear", 32'(teller_pending), 32'd0);

        // Two clients, all tellers at once: teller 0 then 1, teller 2 left pending.
        apply_reset();
        repeat (2) pulse_client(drop_seen);
        sb.push_back('{teller: 2'd0, ticket: 8'd0});
        sb.push_back('{teller: 2'd1, ticket: 8'd1});
        pulse_teller(3'b111);
        check("s2_first_valid", 32'(serve_valid), 32'd1);
        tick();
        check("s2_gap", 32'(serve_valid), 32'd0);
        tick();
        check("s2_second_valid", 32'(serve_valid), 32'd1);
        repeat (3) tick();
        check("s2_pending_left", 32'(teller_pending), 32'b100);
        check("s2_q_empty", 32'(q_empty), 32'd1);
        check("s2_no_serve", 32'(serve_valid), 32'd0);

        // Nine clients, no tellers: fills to 8, the ninth is dropped.
        apply_reset();
        drop_count = 0;
        drop_at    = 0;
        for (int i = 1; i <= 9; i++) begin
            pulse_client(drop_seen);
            if (drop_seen) begin
                drop_count++;
                drop_at = i;
            end
        end
        check("s3_drop_count", 32'(drop_count), 32'd1);
        check("s3_drop_at", 32'(drop_at), 32'd9);
        check("s3_q_count_8", 32'(q_count), 32'd8);
        check("s3_q_full", 32'(q_full), 32'd1);
        check("s3_drop_cleared", 32'(q_drop), 32'd0);

        // Full queue: arrival coincides with a dispatch launch, so it is accepted.
        sb.push_back('{teller: 2'd0, ticket: 8'd0});
        teller_req = 3'b001;
        tick();
        teller_req = 3'b000;
        client_in  = 1'b1;
        tick();
        check("s4_serve_valid", 32'(serve_valid), 32'd1);
        check("s4_q_count_8", 32'(q_count), 32'd8);
        check("s4_no_drop", 32'(q_drop), 32'd0);
        client_in = 1'b0;
        tick();
        check("s4_q_full", 32'(q_full), 32'd1);

        // Ticket wrap: 257 dispatches to teller 0, tickets 0..255 then 0.
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            sb.push_back('{teller: 2'd0, ticket: 8'(i)});
            client_in  = 1'b1;
            teller_req = 3'b001;
            tick();
            client_in  = 1'b0;
            teller_req = 3'b000;
            tick();
            tick();
        end
        check("s5_q_empty", 32'(q_empty), 32'd1);
        check("s5_last_ticket", 32'(serve_ticket), 32'd0);

        // Reset during SERVE discards the dispatch; teller 0 first afterwards.
        apply_reset();
        pulse_client(drop_seen);
        teller_req = 3'b001;
        tick();
        teller_req = 3'b000;
        tick();
        check("s6_in_serve", 32'(serve_valid), 32'd1);
        #1 reset_n = 1'b0;
        client_in = 1'b1;
        #1;
        check_reset_state("s6_async");
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("s6_high_at_release", 32'(q_count), 32'd1);
        client_in = 1'b0;
        sb.push_back('{teller: 2'd0, ticket: 8'd0});
        pulse_teller(3'b011);
        check("s6_serve_valid", 32'(serve_valid), 32'd1);
        repeat (2) tick();
        check("s6_pending_left", 32'(teller_pending), 32'b010);
        check("s6_q_empty", 32'(q_empty), 32'd1);

        repeat (3) tick();
        check("missing_dispatches", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/queue_dispatcher.md
QUEUE_DISPATCHER -- requirements
Module: queue_dispatcher

Interface
REQ-001 Parameter N_TELLERS, default 3: number of teller request inputs (2..8).
REQ-002 Parameter DEPTH, default 8: maximum clients waiting.
REQ-003 Parameter TW, default 8: ticket number width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk by the system.
REQ-006 client_in  input  1  entry sensor level, synchronous to clk; each rising edge is one arriving client.
REQ-007 teller_req  input  N_TELLERS  teller "next client" button levels, synchronous to clk; each rising edge is one request.
REQ-008 q_count  output  ceil(log2(DEPTH+1))  clients currently waiting.
REQ-009 q_empty / q_full  output  1 each  q_count==0 / q_count==DEPTH.
REQ-010 q_drop  output  1  one-cycle pulse: arrival rejected because the queue was full.
REQ-011 teller_pending  output  N_TELLERS  latched, not-yet-served teller requests.
REQ-012 serve_valid  output  1  one-cycle dispatch pulse.
REQ-013 serve_teller  output  ceil(log2(N_TELLERS))  teller index granted; valid only with serve_valid.
REQ-014 serve_ticket  output  TW  ticket number dispatched; valid only with serve_valid.

Function
REQ-015 Edge detection: registered previous sample per input; rise = current & ~previous; a level held high produces exactly one event.
REQ-016 Arrival: on a clock edge with client rise and q_count<DEPTH, q_count increments and issue counter increments by 1 (mod 2^TW).
REQ-017 Arrival with q_count==DEPTH and no same-edge dispatch: dropped, counters unchanged, q_drop=1 for the following cycle.
REQ-018 Teller rise sets teller_pending[i]; a rise on an already-pending teller is ignored.
REQ-019 FSM states: IDLE, SERVE.
REQ-020 IDLE -> SERVE when teller_pending!=0 and q_count!=0; otherwise remain IDLE.
REQ-021 On the IDLE->SERVE edge: choose grant round-robin, starting at the index after last_grant and wrapping; clear teller_pending[grant]; load serve_teller=grant and serve_ticket=serve counter; increment serve counter (mod 2^TW); decrement q_count; set last_grant=grant.
REQ-022 In SERVE, serve_valid=1 for exactly one cycle; SERVE -> IDLE unconditionally. Maximum dispatch rate is one per 2 cycles.
REQ-023 Arrival and dispatch on the same edge: q_count unchanged; full-queue arrival is accepted, not dropped.
REQ-024 Teller rise on the dispatch edge for the granted teller: pending is set, because the new request wins over the clear.
REQ-025 Ticket counters wrap from 2^TW-1 to 0 with no other effect.
REQ-026 Outside SERVE, serve_valid=0 and serve_teller/serve_ticket hold their last value.

Reset
REQ-027 On reset_n low, asynchronously: state=IDLE; q_count=0; q_empty=1; q_full=0; q_drop=0; serve_valid=0; serve_teller=0; serve_ticket=0; teller_pending=0; issue and serve counters=0; last_grant=N_TELLERS-1, so teller 0 has first priority; edge-detect registers=0.
REQ-028 Reset mid-SERVE: serve_valid drops immediately, and the in-flight dispatch is discarded with all other state.
REQ-029 An input already high when reset is released counts as a rise on the first clock edge.

Verification
REQ-030 Three client pulses, then teller 1 pulse -> q_count 3; serve_valid one cycle with serve_teller=1 and serve_ticket=0; q_count 2.
REQ-031 q_count=2, all three tellers raised on the same edge -> dispatches in order teller 0, 1 (tickets 0,1), 2 cycles apart; teller_pending=3'b100 remains; q_empty=1.
REQ-032 Nine client pulses with no teller request -> q_count 8, q_full=1; one q_drop pulse on the 9th arrival.
REQ-033 q_full with a dispatch launching on the same edge as an arrival -> q_count stays 8; no q_drop.
REQ-034 Issue and serve counters at 255 -> next serve_ticket 255, then 0.
REQ-035 reset_n pulsed low during SERVE -> all outputs at their REQ-027 values within the same cycle; next teller 0 request is granted first.
